div_seq_unsigned: RTL and testbench
===================================

// Module: div_seq_unsigned
// PURPOSE
//  Parametrised multi-cycle unsigned integer divider: SBC / SC -> quotient Q, remainder R.
//  Restoring shift-subtract algorithm, one quotient bit per clock.
//  Valid/ready handshakes on input and output so it drops into a streaming datapath.
//  Adds divide-by-zero detection and output back-pressure.
// PARAMETERS
//  WIDTH       8   operand, quotient and remainder width in bits (>=2)
//  ZERO_EARLY  1   1: divide-by-zero result is produced without running the iteration loop
// PORTS
//  clk       in   1      rising-edge clock; the block's only clock
//  rst       in   1      synchronous, active-high reset
//  in_valid  in   1      SBC/SC valid
//  in_ready  out  1      block can accept an operand pair
//  SBC       in   WIDTH  dividend
//  SC        in   WIDTH  divisor
//  out_valid out  1      Q/R/DZ valid
//  out_ready in   1      consumer accepts the result
//  Q         out  WIDTH  quotient
//  R         out  WIDTH  remainder
//  DZ        out  1      divide-by-zero flag for the current result
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, Q=0, R=0, DZ=0, FSM=IDLE.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE, on in_valid&in_ready: latch SBC and SC.
//    If SC==0 && ZERO_EARLY: go to DONE with Q=all-ones, R=SBC, DZ=1.
//    Otherwise: go to RUN. Load rem=0, quo=SBC, cnt=WIDTH-1.
//   RUN, each cycle:
//    rem' = {rem[W-2:0],quo[W-1]} - SC, computed on a (WIDTH+1)-bit difference.
//    If the difference is non-negative, keep it and shift in a quotient bit of 1.
//    Otherwise, restore and shift in a 0.
//    After the cnt==0 iteration, go to DONE.
//   DONE: out_valid=1, and Q/R/DZ are held stable.
//    On out_ready: out_valid drops the next cycle and the FSM returns to IDLE.
//  Handshakes:
//   in_ready=1 only in IDLE.
//   in_valid is ignored in RUN and DONE; no queuing.
//  Latency: acceptance edge to out_valid high = WIDTH+1 cycles (normal); 1 cycle (early zero).
//   Throughput: one op per WIDTH+2 cycles, given out_ready held high.
//  Zero divisor with ZERO_EARLY=0: the loop runs normally.
//   Result is the natural algorithm output: Q=all-ones, R=SBC. DZ=1.
//  Q and R update only when entering DONE. They are never exposed mid-iteration.
//  Q*SC+R == SBC and R<SC hold for all SC!=0.
//  rst asserted at any point, including mid-RUN or in DONE with out_ready=0:
//   the op is aborted and all outputs return to reset values the next cycle.
//  out_ready asserted while out_valid=0 has no effect.
// STRUCTURE
//  Shared package div_pkg holds:
//   - state typedef/localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//   - default WIDTH
//   - counter width function clog2(WIDTH)
//  Sub-module div_step: combinational single restoring iteration.
//   Inputs: rem, msb-in, divisor. Outputs: next rem, quotient bit.
//   Instanced once in the RUN datapath.
//  Top holds the FSM, counter, and operand/result registers.
// TESTING
//  1. WIDTH=8: 243/3 -> Q=81 R=0 DZ=0, out_valid exactly 9 cycles after acceptance.
//  2. 100/26 -> Q=3 R=22; 255/9 -> Q=28 R=3; 255/255 -> Q=1 R=0; 50/91 -> Q=0 R=50.
//  3. 231/0 -> Q=255 R=231 DZ=1; latency 1 cycle (ZERO_EARLY=1), 9 cycles (=0).
//  4. out_ready=0 for 5 cycles in DONE:
//     Q/R stable, in_ready=0, a new in_valid is ignored.
//     Release -> out_valid low next cycle, in_ready high.
//  5. rst pulse at iteration 4 of 255/9 -> reset outputs next cycle.
//     A following 100/26 completes correctly.
//  6. WIDTH=16 random sweep (>=10k ops, random in_valid/out_ready):
//     check Q*SC+R==SBC, R<SC, or DZ rules when SC==0.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the sequential divider
package div_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor keeps a non-negative difference below 2^WIDTH, so the top bit is a clean borrow
    always_comb begin
        shifted  = {rem, msb_in};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq_unsigned.sv
// div_seq_unsigned: valid/ready multi-cycle restoring divider, one quotient bit per clock
module div_seq_unsigned
    import div_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter bit ZERO_EARLY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SBC,
    input  logic [WIDTH-1:0] SC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ
);

    localparam int CW = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .msb_in   (quo_q[WIDTH-1]),
        .divisor  (div_q),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                div_d = SC;
                if (ZERO_EARLY && SC == '0) begin
                    state_d = DONE;
                    q_d     = '1;
                    r_d     = SBC;
                    dz_d    = 1'b1;
                end else begin
                    state_d = RUN;
                    rem_d   = '0;
                    quo_d   = SBC;
                    cnt_d   = CW'(WIDTH - 1);
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q - CW'(1);
                // results are published only on the final iteration
                if (cnt_q == '0) begin
                    state_d = DONE;
                    q_d     = {quo_q[WIDTH-2:0], step_bit};
                    r_d     = step_rem;
                    dz_d    = (div_q == '0);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Q         = q_q;
    assign R         = r_q;
    assign DZ        = dz_q;

endmodule

// File: tb/tb_div_seq_unsigned.sv
// tb_div_seq_unsigned: directed and randomized checks of the divider against an arithmetic model
module tb_div_seq_unsigned;

    localparam int NL   = 8;
    localparam int NOPS = 1250;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       iv_a = 1'b0, iv_b = 1'b0, or8 = 1'b0, use_b = 1'b0;
    logic [7:0] sbc8 = 8'd0, sc8 = 8'd0;
    logic       ir_a, ov_a, dz_a, ir_b, ov_b, dz_b;
    logic [7:0] q_a, r_a, q_b, r_b;
    logic       ir, ov, dz;
    logic [7:0] q, r;

    always_comb begin
        ir = use_b ? ir_b : ir_a;
        ov = use_b ? ov_b : ov_a;
        dz = use_b ? dz_b : dz_a;
        q  = use_b ? q_b : q_a;
        r  = use_b ? r_b : r_a;
    end

    div_seq_unsigned #(.WIDTH(8), .ZERO_EARLY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .SBC(sbc8), .SC(sc8),
        .out_valid(ov_a), .out_ready(or8), .Q(q_a), .R(r_a), .DZ(dz_a)
    );

    div_seq_unsigned #(.WIDTH(8), .ZERO_EARLY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .SBC(sbc8), .SC(sc8),
        .out_valid(ov_b), .out_ready(or8), .Q(q_b), .R(r_b), .DZ(dz_b)
    );

    logic        iv16 [NL];
    logic        or16 [NL];
    logic [15:0] a16  [NL];
    logic [15:0] b16  [NL];
    logic        ir16 [NL];
    logic        ov16 [NL];
    logic        dz16 [NL];
    logic [15:0] q16  [NL];
    logic [15:0] r16  [NL];

    for (genvar g = 0; g < NL; g++) begin : lane
        div_seq_unsigned #(.WIDTH(16), .ZERO_EARLY(g % 2)) u (
            .clk(clk), .rst(rst), .in_valid(iv16[g]), .in_ready(ir16[g]), .SBC(a16[g]), .SC(b16[g]),
            .out_valid(ov16[g]), .out_ready(or16[g]), .Q(q16[g]), .R(r16[g]), .DZ(dz16[g])
        );
    end

    function automatic void ref_div(input int w, input longint a, input longint b,
                                    output longint eq, output longint er, output bit edz);
        if (b == 0) begin
            eq  = (longint'(1) << w) - 1;
            er  = a;
            edz = 1'b1;
        end else begin
            eq  = a / b;
            er  = a % b;
            edz = 1'b0;
        end
    endfunction

    // latency counts clock edges with the acceptance edge included
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input int exp_lat, input string tag);
        longint eq, er;
        bit     edz;
        int     lat;
        ref_div(8, a, b, eq, er, edz);
        @(negedge clk);
        sbc8 = a;
        sc8  = b;
        or8  = 1'b0;
        if (use_b) iv_b = 1'b1; else iv_a = 1'b1;
        total++;
        if (ir !== 1'b1) begin bad++; $display("FAIL %s in_ready got=%b want=1", tag, ir); end
        @(posedge clk); #1;
        iv_a = 1'b0;
        iv_b = 1'b0;
        lat  = 1;
        while (ov !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, exp_lat); end
        total++;
        if ({q, r, dz} !== {eq[7:0], er[7:0], edz}) begin
            bad++;
            $display("FAIL %s result got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b", tag, q, r, dz, eq, er, edz);
        end
        @(negedge clk); or8 = 1'b1;
        @(posedge clk); #1; or8 = 1'b0;
        total++;
        if ({ov, ir} !== 2'b01) begin bad++; $display("FAIL %s release got ov=%b ir=%b want ov=0 ir=1", tag, ov, ir); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ir_a, ov_a, q_a, r_a, dz_a} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            bad++; $display("FAIL reset_a got ir=%b ov=%b q=%0d r=%0d dz=%b want 1 0 0 0 0", ir_a, ov_a, q_a, r_a, dz_a);
        end
        total++;
        if ({ir_b, ov_b, q_b, r_b, dz_b} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            bad++; $display("FAIL reset_b got ir=%b ov=%b q=%0d r=%0d dz=%b want 1 0 0 0 0", ir_b, ov_b, q_b, r_b, dz_b);
        end
        total++;
        if ({ir16[0], ov16[0], q16[0], r16[0], dz16[0]} !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0}) begin
            bad++; $display("FAIL reset_16 got ir=%b ov=%b q=%0d r=%0d dz=%b want 1 0 0 0 0", ir16[0], ov16[0], q16[0], r16[0], dz16[0]);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        use_b = 1'b0;
        do_op8(8'd243, 8'd3, 9, "243/3");
        do_op8(8'd100, 8'd26, 9, "100/26");
        do_op8(8'd255, 8'd9, 9, "255/9");
        do_op8(8'd255, 8'd255, 9, "255/255");
        do_op8(8'd50, 8'd91, 9, "50/91");
    endtask

    task automatic test_zero;
        use_b = 1'b0;
        do_op8(8'd231, 8'd0, 1, "231/0 early");
        use_b = 1'b1;
        do_op8(8'd231, 8'd0, 9, "231/0 loop");
        do_op8(8'd100, 8'd26, 9, "100/26 loop");
        use_b = 1'b0;
    endtask

    task automatic test_random8;
        logic [7:0] a, b;
        for (int s = 0; s < 2; s++) begin
            use_b = s[0];
            for (int i = 0; i < 30; i++) begin
                a = 8'($urandom);
                b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                do_op8(a, b, (b == 8'd0 && !use_b) ? 1 : 9, use_b ? "rand8_loop" : "rand8_early");
            end
        end
        use_b = 1'b0;
    endtask

    task automatic test_backpressure;
        int n;
        use_b = 1'b0;
        @(negedge clk);
        sbc8 = 8'd255; sc8 = 8'd9; or8 = 1'b0; iv_a = 1'b1;
        @(posedge clk); #1; iv_a = 1'b0;
        n = 0;
        while (ov !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        total++;
        if (ov !== 1'b1) begin bad++; $display("FAIL bp_wait out_valid got=%b want=1", ov); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv_a = 1'b1; sbc8 = 8'($urandom); sc8 = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            total++;
            if ({ov, ir, q, r} !== {1'b1, 1'b0, 8'd28, 8'd3}) begin
                bad++; $display("FAIL bp_hold%0d got ov=%b ir=%b q=%0d r=%0d want 1 0 28 3", i, ov, ir, q, r);
            end
        end
        @(negedge clk); iv_a = 1'b0; or8 = 1'b1;
        @(posedge clk); #1; or8 = 1'b0;
        total++;
        if ({ov, ir} !== 2'b01) begin bad++; $display("FAIL bp_release got ov=%b ir=%b want 0 1", ov, ir); end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if ({ov, ir} !== 2'b01) begin bad++; $display("FAIL bp_no_queue got ov=%b ir=%b want 0 1", ov, ir); end
    endtask

    task automatic test_reset_midrun;
        int n;
        use_b = 1'b0;
        @(negedge clk);
        sbc8 = 8'd255; sc8 = 8'd9; or8 = 1'b0; iv_a = 1'b1;
        @(posedge clk); #1; iv_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ir, ov, q, r, dz} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            bad++; $display("FAIL rst_midrun got ir=%b ov=%b q=%0d r=%0d dz=%b want 1 0 0 0 0", ir, ov, q, r, dz);
        end
        @(negedge clk); rst = 1'b0;
        do_op8(8'd100, 8'd26, 9, "100/26 after rst");
        @(negedge clk);
        sbc8 = 8'd77; sc8 = 8'd0; iv_a = 1'b1;
        @(posedge clk); #1; iv_a = 1'b0;
        n = 0;
        while (ov !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ir, ov, q, r, dz} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            bad++; $display("FAIL rst_done got ir=%b ov=%b q=%0d r=%0d dz=%b want 1 0 0 0 0", ir, ov, q, r, dz);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        int last, seen;
        last = -1;
        seen = 0;
        use_b = 1'b0;
        @(negedge clk);
        sbc8 = 8'd200; sc8 = 8'd7; iv_a = 1'b1; or8 = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (ov === 1'b1) begin
                total++;
                if ({q, r, dz} !== {8'd28, 8'd4, 1'b0}) begin
                    bad++; $display("FAIL b2b_result got q=%0d r=%0d dz=%b want 28 4 0", q, r, dz);
                end
                if (last >= 0) begin
                    total++;
                    if (c - last != 10) begin bad++; $display("FAIL b2b_period got=%0d want=10", c - last); end
                end
                last = c;
                seen++;
            end
        end
        total++;
        if (seen < 4) begin bad++; $display("FAIL b2b_count got=%0d want>=4", seen); end
        @(negedge clk); iv_a = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk); or8 = 1'b0;
    endtask

    task automatic run_lane(input int l);
        int          done_ops, cyc;
        bit          pend;
        logic [15:0] pa, pb;
        longint      eq, er;
        bit          edz;
        done_ops = 0; cyc = 0; pend = 1'b0; pa = '0; pb = '0;
        while (done_ops < NOPS && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            a16[l]  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            case ($urandom_range(0, 9))
                0:       b16[l] = 16'd0;
                1, 2, 3: b16[l] = 16'($urandom_range(1, 15));
                default: b16[l] = 16'($urandom);
            endcase
            iv16[l] = ($urandom_range(0, 3) != 0);
            or16[l] = ($urandom_range(0, 3) != 0);
            if (ov16[l] === 1'b1) begin
                total++;
                if (ir16[l] !== 1'b0) begin bad++; $display("FAIL lane%0d ready_in_done got=%b want=0", l, ir16[l]); end
            end
            if (ov16[l] === 1'b1 && or16[l]) begin
                ref_div(16, longint'(pa), longint'(pb), eq, er, edz);
                total++;
                if (!pend || {q16[l], r16[l], dz16[l]} !== {eq[15:0], er[15:0], edz}) begin
                    bad++;
                    $display("FAIL lane%0d result a=%0d b=%0d pend=%b got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                             l, pa, pb, pend, q16[l], r16[l], dz16[l], eq, er, edz);
                end
                if (pb != 16'd0) begin
                    total++;
                    if (longint'(q16[l]) * longint'(pb) + longint'(r16[l]) != longint'(pa) || r16[l] >= pb) begin
                        bad++; $display("FAIL lane%0d identity a=%0d b=%0d got q=%0d r=%0d", l, pa, pb, q16[l], r16[l]);
                    end
                end
                pend = 1'b0;
                done_ops++;
            end
            if (iv16[l] && ir16[l] === 1'b1) begin
                pa   = a16[l];
                pb   = b16[l];
                pend = 1'b1;
            end
        end
        total++;
        if (done_ops < NOPS) begin bad++; $display("FAIL lane%0d timeout got=%0d ops want=%0d", l, done_ops, NOPS); end
        iv16[l] = 1'b0;
    endtask

    task automatic test_sweep16;
        fork
            run_lane(0);
            run_lane(1);
            run_lane(2);
            run_lane(3);
            run_lane(4);
            run_lane(5);
            run_lane(6);
            run_lane(7);
        join
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin
            iv16[i] = 1'b0;
            or16[i] = 1'b0;
            a16[i]  = 16'd0;
            b16[i]  = 16'd0;
        end
        test_reset;
        test_directed;
        test_zero;
        test_random8;
        test_backpressure;
        test_reset_midrun;
        test_back_to_back;
        test_sweep16;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
